// File: rtl/dmem_pkg.sv
// Shared types and the request legality rule for the data-RAM arbiter.
// Pure definitions, no latency; no flow control lives here.
package dmem_pkg;

    typedef enum logic [1:0] {
        DT_WORD    = 2'b00,
        DT_BYTE    = 2'b01,
        DT_HALF    = 2'b10,
        DT_ILLEGAL = 2'b11
    } dtype_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_e;

    // Only the two low address bits matter for natural alignment.
    function automatic logic is_aligned(input logic [1:0] dtype, input logic [1:0] addr_lo);
        case (dtype_e'(dtype))
            DT_WORD: return (addr_lo == 2'b00);
            DT_HALF: return !addr_lo[0];
            DT_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request, response and RAM-side signals of the two-port data-RAM arbiter.
// Wires only; the arbiter side is the slave modport, requesters plus RAM are the master.
interface dmem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [1:0]                          req_valid_i;
    logic [1:0]                          req_ready_o;
    logic [1:0]                          req_we_i;
    logic [1:0][1:0]                     req_type_i;
    logic [1:0][ADDRESS_WIDTH-1:0]       req_addr_i;
    logic [1:0][DATA_WIDTH-1:0]          req_wdata_i;
    logic [1:0]                          rsp_valid_o;
    logic                                rsp_err_o;
    logic [DATA_WIDTH-1:0]               rsp_rdata_o;
    logic                                ram_we_o;
    logic [1:0]                          ram_type_o;
    logic [ADDRESS_WIDTH-1:0]            ram_addr_o;
    logic [DATA_WIDTH-1:0]               ram_wdata_o;
    logic [DATA_WIDTH-1:0]               ram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_type_i, req_addr_i, req_wdata_i, ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output ram_we_o, ram_type_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_type_i, req_addr_i, req_wdata_i, ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  ram_we_o, ram_type_o, ram_addr_o, ram_wdata_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that was not granted last.
// Combinational, zero latency; the caller owns the last-grant register.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer for the single-port data RAM: response 2 cycles after handshake (1 if illegal).
// One access in flight; ready is only offered in IDLE, so a losing or late requester simply holds valid.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    arb_state_e               state;
    logic                     last_grant;
    logic                     owner;
    logic                     lat_we;
    logic [1:0]               lat_type;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic                     rsp_err;
    logic [DATA_WIDTH-1:0]    rsp_rdata;

    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] handshake;
    logic       sel;
    logic       legal;
    logic       in_access;

    rr_arb2 u_rr_arb2 (
        .req_valid  (bus.req_valid_i),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is forced low while reset is held, even though state already reads IDLE.
    assign ready           = (state == IDLE && rst_n) ? grant : 2'b00;
    assign bus.req_ready_o = ready;
    assign handshake       = bus.req_valid_i & ready;
    assign sel             = grant[1];
    assign legal           = is_aligned(bus.req_type_i[sel], bus.req_addr_i[sel][1:0]);

    // RAM strobes decode straight from state so an async reset drops the write at once.
    assign in_access       = (state == ACCESS);
    assign bus.ram_we_o    = in_access & lat_we;
    assign bus.ram_type_o  = in_access ? lat_type  : 2'b00;
    assign bus.ram_addr_o  = in_access ? lat_addr  : '0;
    assign bus.ram_wdata_o = in_access ? lat_wdata : '0;

    assign bus.rsp_valid_o = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_err_o   = (state == RESP) & rsp_err;
    assign bus.rsp_rdata_o = (state == RESP) ? rsp_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_type   <= 2'b00;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|handshake) begin
                        owner      <= sel;
                        last_grant <= sel;
                        lat_we     <= bus.req_we_i[sel];
                        lat_type   <= bus.req_type_i[sel];
                        lat_addr   <= bus.req_addr_i[sel];
                        lat_wdata  <= bus.req_wdata_i[sel];
                        rsp_rdata  <= '0;
                        rsp_err    <= !legal;
                        state      <= legal ? ACCESS : RESP;
                    end
                end
                ACCESS: begin
                    rsp_rdata <= lat_we ? '0 : bus.ram_rdata_i;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array RAM model on the RAM port, transaction-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- RAM model (little-endian, zero-extending) ----------------
    logic [7:0]  ram [256] = '{default: 8'h00};
    logic [7:0]  ra;
    logic [31:0] ram_rd;
    assign ra = bus.ram_addr_o[7:0];

    always_comb begin
        ram_rd = 32'h0;
        case (bus.ram_type_o)
            2'b00:   ram_rd = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
            2'b01:   ram_rd = {24'h0, ram[ra]};
            2'b10:   ram_rd = {16'h0, ram[ra + 8'd1], ram[ra]};
            default: ram_rd = 32'h0;
        endcase
    end
    assign bus.ram_rdata_i = ram_rd;

    always @(posedge clk) begin
        if (bus.ram_we_o) begin
            for (int i = 0; i < 4; i++) begin
                if (i < ((bus.ram_type_o == 2'b00) ? 4 : (bus.ram_type_o == 2'b10) ? 2 : 1))
                    ram[ra + 8'(i)] <= bus.ram_wdata_o[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    function automatic logic ref_legal(input logic [1:0] t, input int a);
        if (t == 2'b11) return 1'b0;
        if (t == 2'b00) return (a % 4) == 0;
        if (t == 2'b10) return (a % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] t, input int a);
        logic [31:0] w;
        int base;
        base = a - (a % 4);
        w = 32'h0;
        for (int i = 0; i < 4; i++) w = w | (32'(ref_mem[(base + i) % 256]) << (8 * i));
        w = w >> (8 * (a % 4));
        if (t == 2'b01) return w & 32'hFF;
        if (t == 2'b10) return w & 32'hFFFF;
        return w;
    endfunction

    int          busy = 0, rsp_in = -1, acc_in = -1;
    logic        m_last = 1'b1;
    logic        p_owner, p_err, p_we;
    logic [1:0]  p_type;
    logic [31:0] p_data, p_addr, p_wdata;
    int          cyc = 0, rsp_cnt = 0, we_hi_cnt = 0;
    int          last_hs_cyc = 0, last_rsp_cyc = 0;
    logic        last_rsp_err;
    logic [31:0] last_rsp_data;
    logic [1:0]  taken = 2'b00;
    int          grant_q[$];
    int          gcyc_q[$];

    always @(negedge clk) begin
        logic [1:0] v, exp_rdy;
        int pt, a;
        if (!rst_n) begin
            check("rst_ready", 32'(bus.req_ready_o), 32'h0);
            check("rst_rsp_vld", 32'(bus.rsp_valid_o), 32'h0);
            check("rst_rsp_err", 32'(bus.rsp_err_o), 32'h0);
            check("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
            check("rst_ram_we", 32'(bus.ram_we_o), 32'h0);
            check("rst_ram_addr", bus.ram_addr_o, 32'h0);
            busy = 0; rsp_in = -1; acc_in = -1; m_last = 1'b1;
        end else begin
            cyc++;
            if (busy > 0) busy--;
            if (rsp_in >= 0) rsp_in--;
            if (acc_in >= 0) acc_in--;
            v = bus.req_valid_i;
            exp_rdy = 2'b00;
            if (busy == 0) begin
                if (v == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
                else exp_rdy = v;
            end
            check("ready", 32'(bus.req_ready_o), 32'(exp_rdy));
            check("rsp_vld", 32'(bus.rsp_valid_o), (rsp_in == 0) ? (32'h1 << p_owner) : 32'h0);
            if (rsp_in == 0) begin
                check("rsp_err", 32'(bus.rsp_err_o), 32'(p_err));
                check("rsp_rdata", bus.rsp_rdata_o, p_data);
                last_rsp_err = bus.rsp_err_o;
                last_rsp_data = bus.rsp_rdata_o;
                last_rsp_cyc = cyc;
                rsp_cnt++;
            end
            if (bus.ram_we_o) we_hi_cnt++;
            check("ram_we", 32'(bus.ram_we_o), 32'((acc_in == 0) && p_we));
            check("ram_addr", bus.ram_addr_o, (acc_in == 0) ? p_addr : 32'h0);
            if (acc_in == 0) begin
                check("ram_type", 32'(bus.ram_type_o), 32'(p_type));
                if (p_we) begin
                    check("ram_wdata", bus.ram_wdata_o, p_wdata);
                    a = int'(p_addr - 32'h10000);
                    for (int i = 0; i < ((p_type == 2'b00) ? 4 : (p_type == 2'b10) ? 2 : 1); i++)
                        ref_mem[(a + i) % 256] = p_wdata[8*i +: 8];
                end
            end
            if (exp_rdy != 2'b00 && (v & exp_rdy) != 2'b00) begin
                pt = exp_rdy[1] ? 1 : 0;
                m_last = pt[0];
                p_owner = pt[0];
                p_we = bus.req_we_i[pt];
                p_type = bus.req_type_i[pt];
                p_addr = bus.req_addr_i[pt];
                p_wdata = bus.req_wdata_i[pt];
                a = int'(p_addr - 32'h10000);
                p_err = !ref_legal(p_type, a);
                p_data = (!p_err && !p_we) ? ref_load(p_type, a) : 32'h0;
                busy = p_err ? 2 : 3;
                rsp_in = p_err ? 1 : 2;
                acc_in = p_err ? -1 : 1;
                if (p_err) p_we = 1'b0;
                taken[pt] = 1'b1;
                last_hs_cyc = cyc;
                grant_q.push_back(pt);
                gcyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic v, input logic we, input logic [1:0] t,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid_i[p] = v;
        bus.req_we_i[p]    = we;
        bus.req_type_i[p]  = t;
        bus.req_addr_i[p]  = addr;
        bus.req_wdata_i[p] = wd;
    endtask

    task automatic do_req(input int p, input logic we, input logic [1:0] t,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n, rc0;
        @(posedge clk); #1;
        taken[p] = 1'b0;
        rc0 = rsp_cnt;
        drive(p, 1'b1, we, t, addr, wd);
        n = 0;
        while (!taken[p] && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) check("hs_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        bus.req_valid_i[p] = 1'b0;
        n = 0;
        while (rsp_cnt == rc0 && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) check("rsp_timeout", 32'h0, 32'h1);
    endtask

    task automatic new_req(input int p);
        logic [1:0] t;
        logic [31:0] addr;
        int r;
        r = $urandom_range(0, 7);
        t = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
        addr = 32'h10000 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) addr = addr & ((t == 2'b00) ? ~32'h3 : (t == 2'b10) ? ~32'h1 : ~32'h0);
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), t, addr, $urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, we0, rc0;
        // Both ports already requesting while reset is held: ready must stay low.
        drive(0, 1'b1, 1'b0, 2'b00, 32'h10000, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b00, 32'h10004, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous loads held continuously: 0 first, 1 three cycles later, then alternating.
        n = 0;
        while (grant_q.size() < 4 && n < 30) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_valid_i = 2'b00;
        check("sim_grants", 32'(grant_q.size()), 32'd4);
        if (grant_q.size() >= 4) begin
            check("sim_g0", 32'(grant_q[0]), 32'd0);
            check("sim_g1", 32'(grant_q[1]), 32'd1);
            check("sim_g2", 32'(grant_q[2]), 32'd0);
            check("sim_g3", 32'(grant_q[3]), 32'd1);
            check("sim_gap", 32'(gcyc_q[1] - gcyc_q[0]), 32'd3);
        end
        repeat (4) @(negedge clk);

        // Word store then load-back.
        do_req(0, 1'b1, 2'b00, 32'h10000, 32'hDEADBEEF);
        do_req(0, 1'b0, 2'b00, 32'h10000, 32'h0);
        check("ld_word", last_rsp_data, 32'hDEADBEEF);
        check("ld_err", 32'(last_rsp_err), 32'h0);
        check("ld_lat", 32'(last_rsp_cyc - last_hs_cyc), 32'd2);

        // Illegal requests never reach the RAM.
        we0 = we_hi_cnt;
        do_req(0, 1'b0, 2'b00, 32'h10002, 32'h0);
        check("ill_word_err", 32'(last_rsp_err), 32'h1);
        check("ill_word_lat", 32'(last_rsp_cyc - last_hs_cyc), 32'd1);
        do_req(1, 1'b1, 2'b10, 32'h10001, 32'h11111111);
        check("ill_half_err", 32'(last_rsp_err), 32'h1);
        check("ill_half_data", last_rsp_data, 32'h0);
        do_req(0, 1'b1, 2'b11, 32'h10000, 32'h22222222);
        check("ill_type_err", 32'(last_rsp_err), 32'h1);
        check("ill_we_cnt", 32'(we_hi_cnt - we0), 32'h0);

        // Sub-word loads are zero-extended by the RAM.
        do_req(1, 1'b1, 2'b00, 32'h10008, 32'h80FF7F01);
        do_req(0, 1'b0, 2'b01, 32'h1000B, 32'h0);
        check("ld_byte", last_rsp_data, 32'h00000080);
        do_req(1, 1'b0, 2'b10, 32'h1000A, 32'h0);
        check("ld_half", last_rsp_data, 32'h000080FF);

        // Reset pulse in the middle of an ACCESS cycle aborts the store.
        do_req(1, 1'b1, 2'b00, 32'h1000C, 32'hA5A5A5A5);
        @(posedge clk); #1;
        taken[1] = 1'b0;
        drive(1, 1'b1, 1'b1, 2'b00, 32'h1000C, 32'h12345678);
        @(negedge clk); #1;
        check("rst_hs", 32'(taken[1]), 32'h1);
        @(posedge clk); #2;
        check("acc_we_hi", 32'(bus.ram_we_o), 32'h1);
        rst_n = 1'b0;
        bus.req_valid_i = 2'b00;
        #1 check("async_we_drop", 32'(bus.ram_we_o), 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        rc0 = rsp_cnt;
        repeat (4) @(negedge clk);
        check("rst_no_rsp", 32'(rsp_cnt - rc0), 32'h0);
        do_req(1, 1'b0, 2'b00, 32'h1000C, 32'h0);
        check("rst_keep_data", last_rsp_data, 32'hA5A5A5A5);

        // Randomized traffic; each port holds its request until it is taken.
        taken = 2'b00;
        new_req(0);
        new_req(1);
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (taken[p]) begin
                    taken[p] = 1'b0;
                    new_req(p);
                end else if (!bus.req_valid_i[p] && $urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end
        end
        @(posedge clk); #1;
        bus.req_valid_i = 2'b00;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
